// File: rtl/packed_intc_route_ctrl_pkg.sv
// rtl/packed_intc_route_ctrl_pkg.sv - shared sizes and types for the Benes route controller
package packed_intc_route_ctrl_pkg;

  localparam int PORT_NUM   = 32;
  localparam int SWITCH_NUM = PORT_NUM / 2;
  localparam int STAGE_NUM  = 2 * $clog2(PORT_NUM) - 1;
  localparam int CFG_DEPTH  = 16;
  localparam int LEN_W      = 8;
  localparam int TAG_W      = 8;
  localparam int NET_LAT    = 12;
  localparam int ADDR_W     = $clog2(CFG_DEPTH);
  localparam int SEL_W      = STAGE_NUM * SWITCH_NUM;

  typedef logic [0:STAGE_NUM-1][0:SWITCH_NUM-1] switch_set_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } route_state_e;

  typedef struct packed {
    switch_set_t mod_set;
    switch_set_t slot_set;
  } cfg_entry_t;

endpackage

// File: rtl/packed_intc_cfg_ram.sv
// rtl/packed_intc_cfg_ram.sv - route config table: sync read, read-before-write, per-entry valid bits
module packed_intc_cfg_ram
  import packed_intc_route_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  switch_set_t       wr_mod,
  input  switch_set_t       wr_slot,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output switch_set_t       rd_mod,
  output switch_set_t       rd_slot,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_valid
);

  cfg_entry_t           mem [CFG_DEPTH];
  logic [CFG_DEPTH-1:0] valid;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= '{mod_set: wr_mod, slot_set: wr_slot};
    end
  end

  // Read registers double as the driven selects, so they only move on rd_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= '0;
      rd_mod  <= '0;
      rd_slot <= '0;
    end else begin
      if (wr_en) begin
        valid[wr_addr] <= 1'b1;
      end
      if (rd_en) begin
        rd_mod  <= mem[rd_addr].mod_set;
        rd_slot <= mem[rd_addr].slot_set;
      end
    end
  end

  assign chk_valid = valid[chk_addr];

endmodule

// File: rtl/packed_intc_route_ctrl.sv
// rtl/packed_intc_route_ctrl.sv - route request FSM, select drive and beat marker delay line
// Optional saturating statistics outputs under ROUTE_CTRL_STATS_EN.
module packed_intc_route_ctrl
  import packed_intc_route_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [SEL_W-1:0]  cfg_mod_set,
  input  logic [SEL_W-1:0]  cfg_slot_set,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_id,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [SEL_W-1:0]  o_module_select,
  output logic [SEL_W-1:0]  o_slot_select,
  output logic              o_data_valid,
  output logic [TAG_W-1:0]  o_data_tag,
  output logic              o_data_last,
  output logic              o_busy,
  output logic              o_err
`ifdef ROUTE_CTRL_STATS_EN
  ,
  output logic [31:0]       o_beat_cnt,
  output logic [15:0]       o_drop_cnt
`endif
);

  route_state_e      state;
  logic [ADDR_W-1:0] id_q;
  logic [LEN_W-1:0]  len_q;
  logic [TAG_W-1:0]  tag_q;
  logic [LEN_W-1:0]  cnt;
  logic              hit;
  logic              accept;
  logic              drop;
  logic              last_beat;

  logic              launch_valid;
  logic              launch_last;
  logic [TAG_W-1:0]  launch_tag;

  logic [NET_LAT-1:0] dl_valid;
  logic [NET_LAT-1:0] dl_last;
  logic [TAG_W-1:0]   dl_tag [NET_LAT];

  packed_intc_cfg_ram u_cfg_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (cfg_we),
    .wr_addr   (cfg_addr),
    .wr_mod    (cfg_mod_set),
    .wr_slot   (cfg_slot_set),
    .rd_en     (state == LOAD),
    .rd_addr   (id_q),
    .rd_mod    (o_module_select),
    .rd_slot   (o_slot_select),
    .chk_addr  (req_id),
    .chk_valid (hit)
  );

  assign accept    = req_valid & req_ready;
  assign drop      = accept & ~hit;
  assign last_beat = (cnt == len_q);

  // req_ready is registered: it is precomputed for the cycle it applies to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      o_err     <= 1'b0;
      id_q      <= '0;
      len_q     <= '0;
      tag_q     <= '0;
      cnt       <= '0;
    end else begin
      if (drop) begin
        o_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept && hit) begin
            state     <= LOAD;
            req_ready <= 1'b0;
            id_q      <= req_id;
            len_q     <= req_len;
            tag_q     <= req_tag;
          end
        end
        LOAD: begin
          state     <= STREAM;
          cnt       <= '0;
          req_ready <= (len_q == '0);
        end
        STREAM: begin
          if (last_beat) begin
            if (accept && hit) begin
              state     <= LOAD;
              req_ready <= 1'b0;
              id_q      <= req_id;
              len_q     <= req_len;
              tag_q     <= req_tag;
            end else begin
              state     <= IDLE;
              req_ready <= 1'b1;
            end
          end else begin
            cnt       <= cnt + LEN_W'(1);
            req_ready <= ((cnt + LEN_W'(1)) == len_q);
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

  assign launch_valid = (state == STREAM);
  assign launch_last  = launch_valid & last_beat;
  assign launch_tag   = launch_valid ? tag_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid <= '0;
      dl_last  <= '0;
      for (int i = 0; i < NET_LAT; i++) begin
        dl_tag[i] <= '0;
      end
    end else begin
      dl_valid  <= {dl_valid[NET_LAT-2:0], launch_valid};
      dl_last   <= {dl_last[NET_LAT-2:0], launch_last};
      dl_tag[0] <= launch_tag;
      for (int i = 1; i < NET_LAT; i++) begin
        dl_tag[i] <= dl_tag[i-1];
      end
    end
  end

  assign o_data_valid = dl_valid[NET_LAT-1];
  assign o_data_last  = dl_last[NET_LAT-1];
  assign o_data_tag   = dl_tag[NET_LAT-1];
  assign o_busy       = (state != IDLE) | (|dl_valid);

`ifdef ROUTE_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_beat_cnt <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (o_data_valid && (o_beat_cnt != '1)) begin
        o_beat_cnt <= o_beat_cnt + 32'd1;
      end
      if (drop && (o_drop_cnt != '1)) begin
        o_drop_cnt <= o_drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_packed_intc_route_ctrl.sv
// tb/tb_packed_intc_route_ctrl.sv - directed self-checking bench for packed_intc_route_ctrl
module tb_packed_intc_route_ctrl;
  import packed_intc_route_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [SEL_W-1:0]  cfg_mod_set = '0;
  logic [SEL_W-1:0]  cfg_slot_set = '0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_id = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic [SEL_W-1:0]  o_module_select;
  logic [SEL_W-1:0]  o_slot_select;
  logic              o_data_valid;
  logic [TAG_W-1:0]  o_data_tag;
  logic              o_data_last;
  logic              o_busy;
  logic              o_err;
`ifdef ROUTE_CTRL_STATS_EN
  logic [31:0]       o_beat_cnt;
  logic [15:0]       o_drop_cnt;
`endif

  packed_intc_route_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_mod_set     (cfg_mod_set),
    .cfg_slot_set    (cfg_slot_set),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_id          (req_id),
    .req_len         (req_len),
    .req_tag         (req_tag),
    .o_module_select (o_module_select),
    .o_slot_select   (o_slot_select),
    .o_data_valid    (o_data_valid),
    .o_data_tag      (o_data_tag),
    .o_data_last     (o_data_last),
    .o_busy          (o_busy),
    .o_err           (o_err)
`ifdef ROUTE_CTRL_STATS_EN
    ,
    .o_beat_cnt      (o_beat_cnt),
    .o_drop_cnt      (o_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              at;
    logic [TAG_W-1:0] tag;
    logic            last;
  } beat_t;
  beat_t beats[$];

  always @(negedge clk) begin
    if (o_data_valid === 1'b1) beats.push_back('{cyc, o_data_tag, o_data_last});
  end

  int errors = 0;
  int checks = 0;

  logic [SEL_W-1:0] m3, s3, m5, s5, m3b, s3b;

  task automatic chk(input string name, input logic [SEL_W-1:0] obs, input logic [SEL_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic write_cfg(input int addr, input logic [SEL_W-1:0] m, input logic [SEL_W-1:0] s);
    cfg_we = 1'b1; cfg_addr = ADDR_W'(addr); cfg_mod_set = m; cfg_slot_set = s;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Presents one request at the current cycle (handshake cycle th), returns at th+1.
  task automatic send(input int id, input int len, input int tag, output int th);
    req_id = ADDR_W'(id); req_len = LEN_W'(len); req_tag = TAG_W'(tag); req_valid = 1'b1;
    th = cyc;
    chk("send_ready", SEL_W'(req_ready), SEL_W'(1));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && o_busy !== 1'b0; i++) @(negedge clk);
    chk("idle_timeout", SEL_W'(o_busy), SEL_W'(0));
    @(negedge clk);
  endtask

  initial begin
    int th, th2;
    m3  = {9{16'hA5C3}}; s3  = {9{16'h0F1E}};
    m5  = {9{16'h1234}}; s5  = {9{16'hFEDC}};
    m3b = {9{16'h5A3C}}; s3b = {9{16'hC0DE}};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mod_sel", o_module_select, '0);
    chk("rst_slot_sel", o_slot_select, '0);
    chk("rst_valid", SEL_W'(o_data_valid), '0);
    chk("rst_busy", SEL_W'(o_busy), '0);
    chk("rst_err", SEL_W'(o_err), '0);
    chk("rst_ready", SEL_W'(req_ready), '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", SEL_W'(req_ready), SEL_W'(1));

    // 1: single beat, select and beat latency
    write_cfg(3, m3, s3);
    write_cfg(5, m5, s5);
    beats.delete();
    send(3, 0, 8'hA5, th);
    chk("t1_sel_load_old", o_module_select, '0);
    chk("t1_ready_load", SEL_W'(req_ready), '0);
    wait_to(th + 2);
    chk("t1_mod_sel", o_module_select, m3);
    chk("t1_slot_sel", o_slot_select, s3);
    chk("t1_busy", SEL_W'(o_busy), SEL_W'(1));
    wait_to(th + 2 + NET_LAT);
    chk("t1_busy_last", SEL_W'(o_busy), SEL_W'(1));
    wait_to(th + 3 + NET_LAT);
    chk("t1_busy_fall", SEL_W'(o_busy), '0);
    @(negedge clk);
    chk("t1_nbeats", SEL_W'(beats.size()), SEL_W'(1));
    if (beats.size() == 1) begin
      chk("t1_beat_cyc", SEL_W'(beats[0].at), SEL_W'(th + 2 + NET_LAT));
      chk("t1_beat_tag", SEL_W'(beats[0].tag), SEL_W'(8'hA5));
      chk("t1_beat_last", SEL_W'(beats[0].last), SEL_W'(1));
    end

    // 2: LEN=4 then back-to-back request held valid
    beats.delete();
    req_id = 5; req_len = 4; req_tag = 8'h11; req_valid = 1'b1;
    th = cyc;
    chk("t2_ready0", SEL_W'(req_ready), SEL_W'(1));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin req_id = 3; req_len = 1; req_tag = 8'h22; end
      chk($sformatf("t2_ready_k%0d", k), SEL_W'(req_ready), SEL_W'(k == 6));
      if (k == 1) chk("t2_sel_held", o_module_select, m3);
      if (k == 2) chk("t2_sel_m5", o_module_select, m5);
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("t2_sel_bubble", o_module_select, m5);
    @(negedge clk);
    chk("t2_sel_second", o_module_select, m3);
    wait_idle();
    chk("t2_nbeats", SEL_W'(beats.size()), SEL_W'(7));
    if (beats.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        int ec;
        logic [7:0] et;
        logic el;
        ec = (i < 5) ? th + 2 + NET_LAT + i : th + 3 + NET_LAT + i;
        et = (i < 5) ? 8'h11 : 8'h22;
        el = (i == 4) || (i == 6);
        chk($sformatf("t2_cyc%0d", i), SEL_W'(beats[i].at), SEL_W'(ec));
        chk($sformatf("t2_tag%0d", i), SEL_W'(beats[i].tag), SEL_W'(et));
        chk($sformatf("t2_last%0d", i), SEL_W'(beats[i].last), SEL_W'(el));
      end
    end

    // 3: unwritten entry
    beats.delete();
    send(7, 0, 8'h77, th);
    chk("t3_err", SEL_W'(o_err), SEL_W'(1));
    chk("t3_ready", SEL_W'(req_ready), SEL_W'(1));
    chk("t3_busy", SEL_W'(o_busy), '0);
    repeat (20) @(negedge clk);
    chk("t3_no_beats", SEL_W'(beats.size()), '0);
    send(3, 2, 8'h33, th2);
    wait_idle();
    chk("t3_ok_nbeats", SEL_W'(beats.size()), SEL_W'(3));
    if (beats.size() == 3) begin
      chk("t3_ok_cyc", SEL_W'(beats[0].at), SEL_W'(th2 + 2 + NET_LAT));
      chk("t3_ok_tag", SEL_W'(beats[2].tag), SEL_W'(8'h33));
      chk("t3_ok_last", SEL_W'({beats[0].last, beats[1].last, beats[2].last}), SEL_W'(3'b001));
    end
    chk("t3_err_sticky", SEL_W'(o_err), SEL_W'(1));

    // 4: write during LOAD of same entry reads old data
    send(3, 0, 8'h44, th);
    cfg_we = 1'b1; cfg_addr = 3; cfg_mod_set = m3b; cfg_slot_set = s3b;
    @(negedge clk);
    cfg_we = 1'b0;
    chk("t4_old_mod", o_module_select, m3);
    chk("t4_old_slot", o_slot_select, s3);
    @(negedge clk);
    chk("t4_held_mod", o_module_select, m3);
    wait_idle();
    send(3, 0, 8'h45, th2);
    wait_to(th2 + 2);
    chk("t4_new_mod", o_module_select, m3b);
    chk("t4_new_slot", o_slot_select, s3b);
    wait_idle();

    // 5: reset mid-stream
    send(5, 10, 8'h55, th);
    wait_to(th + 5);
    chk("t5_streaming", SEL_W'(o_busy), SEL_W'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_mod", o_module_select, '0);
    chk("t5_rst_slot", o_slot_select, '0);
    chk("t5_rst_busy", SEL_W'(o_busy), '0);
    chk("t5_rst_ready", SEL_W'(req_ready), '0);
    chk("t5_rst_err", SEL_W'(o_err), '0);
    chk("t5_rst_data", SEL_W'({o_data_valid, o_data_last, o_data_tag}), '0);
    beats.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("t5_no_stale", SEL_W'(beats.size()), '0);
    chk("t5_idle", SEL_W'(o_busy), '0);
    send(5, 0, 8'h56, th);
    chk("t5_cfg_cleared", SEL_W'(o_err), SEL_W'(1));

`ifdef ROUTE_CTRL_STATS_EN
    // 6: statistics counters
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    write_cfg(3, m3, s3);
    send(3, 0, 8'h61, th); wait_idle();
    send(3, 2, 8'h62, th); wait_idle();
    send(3, 4, 8'h63, th); wait_idle();
    send(9, 0, 8'h64, th);
    repeat (2) @(negedge clk);
    chk("t6_beat_cnt", SEL_W'(o_beat_cnt), SEL_W'(9));
    chk("t6_drop_cnt", SEL_W'(o_drop_cnt), SEL_W'(1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
